// File: rtl/fp_pkg.sv
// Shared constants and beat layout for the FP operand-alignment path.
package fp_pkg;

  localparam int unsigned FP_WIDTH   = 32;
  localparam int unsigned FP_SHAMT_W = 8;
  localparam int unsigned FP_GROUP_W = 8;
  localparam int unsigned FP_LOG2_W  = $clog2(FP_WIDTH);
  localparam int unsigned FP_LOG2_G  = $clog2(FP_GROUP_W);

  typedef struct packed {
    logic [FP_WIDTH-1:0]  data;
    logic                 sticky;
    logic [FP_LOG2_G-1:0] fine;
  } align_beat_t;

endpackage

// File: rtl/fp_align_stage.sv
// One right-shift stage (by in_amt granules) with sticky collection and an
// elastic valid/ready output register.
module fp_align_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AMT_W   = 2,
  parameter int unsigned GRAN    = 8,
  parameter int unsigned CARRY_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [AMT_W-1:0]   in_amt,
  input  logic               in_sticky,
  input  logic [CARRY_W-1:0] in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic [CARRY_W-1:0] out_carry
);

  logic              load;
  int unsigned       sh;
  logic [WIDTH-1:0]  shifted;
  logic              lost;

  assign load     = !out_valid || out_ready;
  assign in_ready = load;

  always_comb begin
    sh      = 32'(in_amt) * GRAN;
    shifted = in_data >> sh;
    lost    = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < sh) lost = lost | in_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sticky <= 1'b0;
      out_carry  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data   <= shifted;
        out_sticky <= in_sticky | lost;
        out_carry  <= in_carry;
      end
    end
  end

endmodule

// File: rtl/fp_align_shifter.sv
// Two-stage pipelined alignment right-shifter: coarse granule shift, then
// fine shift, with sticky accumulation and out-of-range saturation.
module fp_align_shifter
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH   = FP_WIDTH,
  parameter int unsigned SHAMT_W = FP_SHAMT_W,
  parameter int unsigned GROUP_W = FP_GROUP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_sticky,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic               out_zero
);

  localparam int unsigned LOG2_W   = $clog2(WIDTH);
  localparam int unsigned LOG2_G   = $clog2(GROUP_W);
  localparam int unsigned COARSE_W = LOG2_W - LOG2_G;

  logic                sat;
  logic [WIDTH-1:0]    s0_data;
  logic [COARSE_W-1:0] s0_coarse;
  logic [LOG2_G-1:0]   s0_fine;
  logic                s0_sticky;

  logic                s1_valid;
  logic                s1_ready;
  logic [WIDTH-1:0]    s1_data;
  logic                s1_sticky;
  logic [LOG2_G-1:0]   s1_fine;
  logic [LOG2_G-1:0]   s2_fine_unused;

  // Shifts of WIDTH or more flush everything into sticky rather than wrapping.
  always_comb begin
    sat       = in_shamt >= SHAMT_W'(WIDTH);
    s0_data   = sat ? '0 : in_data;
    s0_coarse = sat ? '0 : in_shamt[LOG2_W-1:LOG2_G];
    s0_fine   = sat ? '0 : in_shamt[LOG2_G-1:0];
    s0_sticky = in_sticky | (sat & (|in_data));
  end

  fp_align_stage #(
    .WIDTH  (WIDTH),
    .AMT_W  (COARSE_W),
    .GRAN   (GROUP_W),
    .CARRY_W(LOG2_G)
  ) u_coarse (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s0_data),
    .in_amt    (s0_coarse),
    .in_sticky (s0_sticky),
    .in_carry  (s0_fine),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_data),
    .out_sticky(s1_sticky),
    .out_carry (s1_fine)
  );

  fp_align_stage #(
    .WIDTH  (WIDTH),
    .AMT_W  (LOG2_G),
    .GRAN   (1),
    .CARRY_W(LOG2_G)
  ) u_fine (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   (s1_data),
    .in_amt    (s1_fine),
    .in_sticky (s1_sticky),
    .in_carry  ('0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sticky(out_sticky),
    .out_carry (s2_fine_unused)
  );

  assign out_zero = (out_data == '0);

endmodule
